lsu_ctrl: RTL

- Load/store unit sitting directly upstream of the 64-bit data memory in the MEM stage.
- Accepts one load/store request at a time from the pipeline. Converts byte addresses to doubleword indices and sequences the memory's read/write strobes.
- Extracts and extends sub-doubleword load data. Performs read-modify-write for sub-doubleword stores, because the memory only writes whole doublewords.
- Flags misaligned and out-of-range accesses instead of touching memory.

---
 rtl/lsu_ctrl.sv | 148 ++++++++++++++
 1 files changed

// File: rtl/lsu_ctrl.sv
// Load/store sequencer in front of a 64-bit doubleword memory: alignment/range checks, sub-dword extract and RMW merge.
// Optional macro LSU_SUBWORD_EN enables byte/half/word accesses; without it only dword accesses are legal.
module lsu_ctrl #(
    parameter int DEPTH = 256,
    parameter int IDX_W = 8
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        req_valid,
    output logic        req_ready,
    input  logic        req_store,
    input  logic [1:0]  req_size,
    input  logic        req_signed,
    input  logic [63:0] req_addr,
    input  logic [63:0] req_wdata,
    output logic        resp_valid,
    output logic [63:0] resp_rdata,
    output logic        resp_fault,
    output logic [63:0] mem_adr,
    output logic [63:0] mem_datain,
    output logic        mem_w,
    output logic        mem_r,
    input  logic [63:0] mem_dataout
);

    typedef enum logic [1:0] {IDLE, RD, WR, RSP} state_t;

    state_t      state_reg;
    logic        store_reg;
    logic        fault_reg;
    logic [60:0] idx_reg;
    logic [63:0] wdata_reg;
    logic [63:0] buf_reg;

    logic        misaligned;
    logic        out_of_range;
    logic        req_fault;
    logic        need_read;
    logic [63:0] load_data;
    logic [63:0] store_data;

    // Index bits above IDX_W must be zero; the low IDX_W bits are compared against DEPTH.
    assign out_of_range = (|req_addr[63:IDX_W+3]) ||
                          ({1'b0, req_addr[IDX_W+2:3]} >= (IDX_W+1)'(DEPTH));

`ifdef LSU_SUBWORD_EN
    logic [1:0]  size_reg;
    logic        signed_reg;
    logic [2:0]  off_reg;
    logic [63:0] shifted;
    logic [63:0] wdata_sh;
    logic [3:0]  nbytes;
    logic [7:0]  full_mask;
    logic [7:0]  lane_mask;

    // Alignment mask grows with size: 000, 001, 011, 111.
    assign misaligned = |(req_addr[2:0] & (3'b111 >> (2'd3 - req_size)));
    assign need_read  = !req_store || (req_size != 2'd3);

    assign shifted = buf_reg >> {off_reg, 3'b000};
    always_comb begin
        load_data = shifted;
        case (size_reg)
            2'd0:    load_data = {{56{signed_reg & shifted[7]}},  shifted[7:0]};
            2'd1:    load_data = {{48{signed_reg & shifted[15]}}, shifted[15:0]};
            2'd2:    load_data = {{32{signed_reg & shifted[31]}}, shifted[31:0]};
            default: load_data = shifted;
        endcase
    end

    assign nbytes    = 4'd1 << size_reg;
    assign full_mask = (nbytes == 4'd8) ? 8'hFF : ((8'd1 << nbytes) - 8'd1);
    assign lane_mask = full_mask << off_reg;
    assign wdata_sh  = wdata_reg << {off_reg, 3'b000};

    // A dword store has every lane enabled, so the merge also covers it without a prior read.
    generate
        for (genvar gi = 0; gi < 8; gi++) begin : g_merge
            assign store_data[8*gi +: 8] = lane_mask[gi] ? wdata_sh[8*gi +: 8] : buf_reg[8*gi +: 8];
        end
    endgenerate
`else
    logic unused_signed;

    assign unused_signed = req_signed;
    assign misaligned    = (req_size != 2'd3) || (|req_addr[2:0]);
    assign need_read     = !req_store;
    assign load_data     = buf_reg;
    assign store_data    = wdata_reg;
`endif

    assign req_fault = misaligned || out_of_range;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_reg  <= IDLE;
            store_reg  <= 1'b0;
            fault_reg  <= 1'b0;
            idx_reg    <= '0;
            wdata_reg  <= '0;
            buf_reg    <= '0;
`ifdef LSU_SUBWORD_EN
            size_reg   <= 2'd0;
            signed_reg <= 1'b0;
            off_reg    <= 3'd0;
`endif
        end else begin
            case (state_reg)
                IDLE: begin
                    if (req_valid) begin
                        store_reg <= req_store;
                        fault_reg <= req_fault;
                        idx_reg   <= req_addr[63:3];
                        wdata_reg <= req_wdata;
`ifdef LSU_SUBWORD_EN
                        size_reg   <= req_size;
                        signed_reg <= req_signed;
                        off_reg    <= req_addr[2:0];
`endif
                        if (req_fault)
                            state_reg <= RSP;
                        else if (need_read)
                            state_reg <= RD;
                        else
                            state_reg <= WR;
                    end
                end
                RD: begin
                    buf_reg   <= mem_dataout;
                    state_reg <= store_reg ? WR : RSP;
                end
                WR:      state_reg <= RSP;
                default: state_reg <= IDLE;
            endcase
        end
    end

    // Strobes decode straight from the state register so reset removes them without waiting for an edge.
    assign req_ready  = (state_reg == IDLE);
    assign mem_r      = (state_reg == RD);
    assign mem_w      = (state_reg == WR);
    assign resp_valid = (state_reg == RSP);
    assign resp_fault = (state_reg == RSP) && fault_reg;
    assign mem_adr    = {3'b000, idx_reg};
    assign mem_datain = (state_reg == WR) ? store_data : 64'd0;
    assign resp_rdata = ((state_reg == RSP) && !store_reg && !fault_reg) ? load_data : 64'd0;

endmodule
